// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: time-shares one external 1-bit full adder
// across a WIDTH-bit operation, LSB first, and reports sum/cout/overflow with a done pulse.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  count;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic           carry;
  logic           accept;
  logic           last_bit;

  assign accept   = (state == IDLE) && start;
  assign last_bit = (count == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    fa_a     = 1'b0;
    fa_b     = 1'b0;
    fa_cin   = 1'b0;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy   = 1'b1;
        fa_a   = a_sr[0];
        fa_b   = b_sr[0];
        fa_cin = carry;
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand shifters, carry flop and result register. Subtraction is a + ~b + 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sr     <= a;
      b_sr     <= sub ? ~b : b;
      carry    <= sub ? 1'b1 : cin;
      count    <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (state == RUN) begin
      sum   <= {fa_s, sum[WIDTH-1:1]};
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      carry <= fa_cout;
      if (last_bit) begin
        // carry still holds the carry into the MSB at this edge
        cout     <= fa_cout;
        overflow <= carry ^ fa_cout;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed + random bench for serial_add_ctrl (WIDTH=8) with a behavioural full adder.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             fa_a, fa_b, fa_cin;
  logic             fa_s, fa_cout;
  logic             busy, done;
  logic [WIDTH-1:0] sum;
  logic             cout, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .fa_a     (fa_a),
    .fa_b     (fa_b),
    .fa_cin   (fa_cin),
    .fa_s     (fa_s),
    .fa_cout  (fa_cout),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  // Shared full-adder cell
  assign fa_s    = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word-level reference: returns {cout, overflow, sum}
  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic ms, input logic mc);
    logic [7:0] bb;
    logic       c0;
    logic [7:0] low;
    logic [8:0] full;
    bb   = ms ? ~mb : mb;
    c0   = ms ? 1'b1 : mc;
    low  = {1'b0, ma[6:0]} + {1'b0, bb[6:0]} + {7'd0, c0};
    full = {1'b0, ma} + {1'b0, bb} + {8'd0, c0};
    return {full[8], low[7] ^ full[8], full[7:0]};
  endfunction

  // One full operation: accept, timing of done, result, return to IDLE.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv, input logic ts,
                       input logic tc, input logic [7:0] es, input logic ec,
                       input logic eo, input string tag);
    int cyc;
    a = ta; b = tbv; sub = ts; cin = tc; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_run"}, 32'(busy), 32'd1);
    check({tag, "_fa_cin_first"}, 32'(fa_cin), ts ? 32'd1 : 32'(tc));
    cyc = 0;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(WIDTH));
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_sum_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    logic [9:0] exp_r;
    logic [7:0] ra, rb;
    logic       rs, rc;

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    do_op(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, "t1_add");
    do_op(8'h10, 8'h01, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, "t2_sub");
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "t3_wrap");
    do_op(8'h7F, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, "t3_ovf");

    // start held through RUN/DONE, operands changed mid-RUN
    a = 8'h5A; b = 8'h33; sub = 1'b0; cin = 1'b0; start = 1'b1;
    tick();
    check("t4_busy", 32'(busy), 32'd1);
    a = 8'h01; b = 8'h02;
    for (int k = 1; k < WIDTH; k++) begin
      tick();
      check("t4_no_early_done", 32'(done), 32'd0);
    end
    tick();
    check("t4_done", 32'(done), 32'd1);
    check("t4_sum_orig", 32'(sum), 32'h8D);
    tick();
    check("t4_edge9_idle", 32'(busy | done), 32'd0);
    tick();
    check("t4_edge10_accept", 32'(busy), 32'd1);
    start = 1'b0;
    for (int k = 0; k < 20 && !done; k++) tick();
    check("t4_second_done", 32'(done), 32'd1);
    check("t4_second_sum", 32'(sum), 32'h03);
    tick();

    // Async reset in the middle of RUN
    a = 8'hFF; b = 8'h00; sub = 1'b0; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("t5_partial", 32'(sum), 32'hF0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_sum", 32'(sum), 32'd0);
    check("t5_rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, "t5_fresh");

    // Random mixed add/sub against the word-level model
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      exp_r = model(ra, rb, rs, rc);
      do_op(ra, rb, rs, rc, exp_r[7:0], exp_r[9], exp_r[8], "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
